dfm_seq: RTL and testbench

- Measurement sequencer for the frequency-meter `measure` datapath.
- On start it performs these steps in order:
  - holds the datapath in reset;
  - opens a gate window of programmable length;
  - waits for the datapath's 64-bit result write;
  - presents the result on a valid/ready port.
- Supports single-shot and continuous modes, abort, and a completion timeout.
- Sits between the AXI register block (config/status) and `measure`.

---
 rtl/dfm_pkg.sv | 20 ++
 rtl/dfm_seq_cnt.sv | 28 ++
 rtl/dfm_seq.sv | 173 +++++++++++++++++
 tb/tb_dfm_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfm_pkg.sv
// Shared types and default timing constants for the frequency-meter measurement sequencer.
package dfm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_GATE = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } dfm_state_t;

    typedef struct packed {
        logic [31:0] ref_cnt;
        logic [31:0] sig_cnt;
    } dfm_result_t;

    localparam int DFM_RST_CYCLES = 4;
    localparam int DFM_TIMEOUT    = 1024;

endpackage

// File: rtl/dfm_seq_cnt.sv
// Loadable down-counter with terminal-count flag, shared by the sequencer's timed phases.
module dfm_seq_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Loaded with length-1, so the phase ends in the cycle the count reads zero.
    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dfm_seq.sv
// Measurement sequencer: resets the measure datapath, opens a timed gate, waits for the result
// strobe and holds the result on a valid/ready port.
//
//   state | meaning
//   IDLE  | datapath held in reset, waiting for start
//   ARM   | datapath held in reset for RST_CYCLES
//   GATE  | gate open for the latched gate length
//   WAIT  | gate closed, waiting for result strobe or timeout
//   DONE  | result valid, waiting for handshake
module dfm_seq
    import dfm_pkg::*;
#(
    parameter int GATE_W     = 32,
    parameter int RST_CYCLES = DFM_RST_CYCLES,
    parameter int TIMEOUT    = DFM_TIMEOUT,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [GATE_W-1:0] cfg_gate_i,
    input  logic              cfg_cont_i,
    output logic              meas_rst_n_o,
    output logic              meas_gate_o,
    input  logic              meas_wr_en_i,
    input  logic [63:0]       meas_wr_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [63:0]       res_data_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  meas_cnt_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (GATE_W > TW) ? GATE_W : TW;

    dfm_state_t        state_q;
    logic [GATE_W-1:0] gate_q;
    logic              cont_q;
    logic              meas_rst_n_q;
    logic              meas_gate_q;
    logic              res_valid_q;
    logic              busy_q;
    logic              timeout_q;
    dfm_result_t       res_data_q;
    logic [CNT_W-1:0]  meas_cnt_q;

    logic              cnt_tc;
    logic              cnt_load;
    logic              cnt_en;
    logic [CW-1:0]     cnt_val;
    logic              start_ok;
    logic              arm_end;
    logic              gate_end;
    logic              rearm;

    // Counter reloads must coincide with the state transitions made below.
    always_comb begin
        start_ok = (state_q == ST_IDLE) && start_i && !stop_i;
        arm_end  = (state_q == ST_ARM)  && cnt_tc && !stop_i;
        gate_end = (state_q == ST_GATE) && cnt_tc && !stop_i;
        rearm    = (state_q == ST_DONE) && res_ready_i && cont_q && !stop_i;
        cnt_en   = (state_q == ST_ARM) || (state_q == ST_GATE) || (state_q == ST_WAIT);
        cnt_load = start_ok || arm_end || gate_end || rearm;
        cnt_val  = CW'(RST_CYCLES - 1);
        if (arm_end) begin
            cnt_val = (gate_q == '0) ? '0 : CW'(gate_q - GATE_W'(1));
        end else if (gate_end) begin
            cnt_val = CW'(TIMEOUT - 1);
        end
    end

    dfm_seq_cnt #(
        .W (CW)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (cnt_val),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            gate_q       <= '0;
            cont_q       <= 1'b0;
            meas_rst_n_q <= 1'b0;
            meas_gate_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            res_data_q   <= '0;
            meas_cnt_q   <= '0;
        end else if (stop_i && (state_q != ST_IDLE)) begin
            state_q      <= ST_IDLE;
            meas_rst_n_q <= 1'b0;
            meas_gate_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        gate_q    <= cfg_gate_i;
                        cont_q    <= cfg_cont_i;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (cnt_tc) begin
                        meas_rst_n_q <= 1'b1;
                        meas_gate_q  <= 1'b1;
                        state_q      <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (cnt_tc) begin
                        meas_gate_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A strobe in the expiry cycle still counts as a result.
                    if (meas_wr_en_i) begin
                        res_data_q  <= meas_wr_data_i;
                        res_valid_q <= 1'b1;
                        meas_cnt_q  <= meas_cnt_q + CNT_W'(1);
                        state_q     <= ST_DONE;
                    end else if (cnt_tc) begin
                        timeout_q    <= 1'b1;
                        meas_rst_n_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q  <= 1'b0;
                        meas_rst_n_q <= 1'b0;
                        if (cont_q) begin
                            state_q <= ST_ARM;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    meas_rst_n_q <= 1'b0;
                    meas_gate_q  <= 1'b0;
                    res_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign meas_rst_n_o = meas_rst_n_q;
    assign meas_gate_o  = meas_gate_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign busy_o       = busy_q;
    assign timeout_o    = timeout_q;
    assign meas_cnt_o   = meas_cnt_q;

endmodule

// File: tb/tb_dfm_seq.sv
// Self-checking bench for dfm_seq: directed scenarios plus randomized measurement rounds,
// with expected timing derived from phase lengths by cycle arithmetic.
module tb_dfm_seq;

    localparam int GATE_W     = 32;
    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 1024;
    localparam int CNT_W      = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              stop_i;
    logic [GATE_W-1:0] cfg_gate_i;
    logic              cfg_cont_i;
    logic              meas_rst_n_o;
    logic              meas_gate_o;
    logic              meas_wr_en_i;
    logic [63:0]       meas_wr_data_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [63:0]       res_data_o;
    logic              busy_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  meas_cnt_o;

    always #5 clk_i = ~clk_i;

    dfm_seq #(
        .GATE_W     (GATE_W),
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .cfg_gate_i     (cfg_gate_i),
        .cfg_cont_i     (cfg_cont_i),
        .meas_rst_n_o   (meas_rst_n_o),
        .meas_gate_o    (meas_gate_o),
        .meas_wr_en_i   (meas_wr_en_i),
        .meas_wr_data_i (meas_wr_data_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .meas_cnt_o     (meas_cnt_o)
    );

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_meas(input int g, input bit cont);
        cfg_gate_i = GATE_W'(g);
        cfg_cont_i = cont;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        cfg_gate_i = $urandom;
        cfg_cont_i = 1'($urandom_range(0, 1));
        chk("start_tmo_clr", 64'(timeout_o), 64'd0);
    endtask

    task automatic stop_now();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("stop_gate", 64'(meas_gate_o), 64'd0);
        chk("stop_rstn", 64'(meas_rst_n_o), 64'd0);
        chk("stop_busy", 64'(busy_o), 64'd0);
        chk("stop_valid", 64'(res_valid_o), 64'd0);
        chk("stop_cnt", 64'(meas_cnt_o), 64'(exp_cnt));
    endtask

    // Called in the first ARM cycle. wr_at = WAIT cycles before the strobe; >= TIMEOUT means none.
    task automatic round(input int g, input int wr_at, input logic [63:0] data,
                         input int rdy_wait, input bit cont, input bit poke);
        int ge = (g == 0) ? 1 : g;
        for (int i = 0; i < RST_CYCLES; i++) begin
            chk("arm_rstn", 64'(meas_rst_n_o), 64'd0);
            chk("arm_gate", 64'(meas_gate_o), 64'd0);
            chk("arm_busy", 64'(busy_o), 64'd1);
            if (poke && i == 1) begin
                meas_wr_en_i   = 1'b1;
                meas_wr_data_i = ~data;
            end
            tick();
            meas_wr_en_i = 1'b0;
        end
        for (int i = 0; i < ge; i++) begin
            chk("gate_rstn", 64'(meas_rst_n_o), 64'd1);
            chk("gate_on", 64'(meas_gate_o), 64'd1);
            chk("gate_valid", 64'(res_valid_o), 64'd0);
            if (poke && i == ge / 2) begin
                start_i    = 1'b1;
                cfg_gate_i = GATE_W'(g + 7);
            end
            tick();
            start_i = 1'b0;
        end
        for (int i = 0; i < wr_at && i < TIMEOUT; i++) begin
            chk("wait_gate", 64'(meas_gate_o), 64'd0);
            chk("wait_valid", 64'(res_valid_o), 64'd0);
            chk("wait_tmo", 64'(timeout_o), 64'd0);
            chk("wait_busy", 64'(busy_o), 64'd1);
            tick();
        end
        if (wr_at >= TIMEOUT) begin
            chk("tmo_set", 64'(timeout_o), 64'd1);
            chk("tmo_busy", 64'(busy_o), 64'd0);
            chk("tmo_valid", 64'(res_valid_o), 64'd0);
            chk("tmo_rstn", 64'(meas_rst_n_o), 64'd0);
            chk("tmo_cnt", 64'(meas_cnt_o), 64'(exp_cnt));
            return;
        end
        chk("wr_gate", 64'(meas_gate_o), 64'd0);
        meas_wr_en_i   = 1'b1;
        meas_wr_data_i = data;
        tick();
        meas_wr_en_i   = 1'b0;
        meas_wr_data_i = {$urandom, $urandom};
        exp_cnt++;
        chk("res_valid", 64'(res_valid_o), 64'd1);
        chk("res_data", res_data_o, data);
        chk("meas_cnt", 64'(meas_cnt_o), 64'(exp_cnt));
        chk("cap_tmo", 64'(timeout_o), 64'd0);
        for (int j = 0; j < rdy_wait; j++) begin
            chk("bp_valid", 64'(res_valid_o), 64'd1);
            chk("bp_data", res_data_o, data);
            chk("bp_no_rearm", 64'(meas_rst_n_o), 64'd1);
            tick();
        end
        chk("hs_data", res_data_o, data);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("hs_valid", 64'(res_valid_o), 64'd0);
        chk("hs_busy", 64'(busy_o), 64'(cont));
        chk("hs_rstn", 64'(meas_rst_n_o), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, want run complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i          = 1'b1;
        start_i        = 1'b0;
        stop_i         = 1'b0;
        cfg_gate_i     = '0;
        cfg_cont_i     = 1'b0;
        meas_wr_en_i   = 1'b0;
        meas_wr_data_i = '0;
        res_ready_i    = 1'b0;
        exp_cnt        = '0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_rstn", 64'(meas_rst_n_o), 64'd0);
        chk("rst_gate", 64'(meas_gate_o), 64'd0);
        chk("rst_valid", 64'(res_valid_o), 64'd0);
        chk("rst_data", res_data_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_tmo", 64'(timeout_o), 64'd0);
        chk("rst_cnt", 64'(meas_cnt_o), 64'd0);

        // Single shot: gate 100, strobe 5 cycles after gate close.
        start_meas(100, 1'b0);
        round(100, 5, 64'h0000_0064_0000_000A, 3, 1'b0, 1'b0);

        // Timeout, then a fresh start clears the flag.
        start_meas(10, 1'b0);
        round(10, TIMEOUT, 64'd0, 0, 1'b0, 1'b0);
        tick();
        chk("tmo_sticky", 64'(timeout_o), 64'd1);
        start_meas(10, 1'b0);
        round(10, 3, 64'h1234_5678_9ABC_DEF0, 0, 1'b0, 1'b0);

        // Strobe in the expiry cycle wins over timeout.
        start_meas(3, 1'b0);
        round(3, TIMEOUT - 1, 64'hCAFE_F00D_0BAD_BEEF, 0, 1'b0, 1'b0);

        // Zero gate length, stale strobe in ARM, start during GATE.
        start_meas(0, 1'b0);
        round(0, 2, 64'h0000_0001_0000_0002, 1, 1'b0, 1'b1);

        // Start and stop together in IDLE.
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("ss_busy", 64'(busy_o), 64'd0);
        tick();
        tick();
        chk("ss_idle", 64'(busy_o), 64'd0);
        chk("ss_rstn", 64'(meas_rst_n_o), 64'd0);

        // Abort at gate cycle 40, later strobe ignored.
        start_meas(100, 1'b0);
        for (int i = 0; i < RST_CYCLES + 39; i++) tick();
        chk("ab_gate_open", 64'(meas_gate_o), 64'd1);
        stop_now();
        meas_wr_en_i   = 1'b1;
        meas_wr_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        meas_wr_en_i = 1'b0;
        tick();
        chk("ab_late_wr", 64'(res_valid_o), 64'd0);
        chk("ab_cnt", 64'(meas_cnt_o), 64'(exp_cnt));

        // Reset in the middle of WAIT.
        start_meas(5, 1'b0);
        for (int i = 0; i < RST_CYCLES + 5 + 3; i++) tick();
        chk("rw_in_wait", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        exp_cnt = '0;
        chk("rw_rstn", 64'(meas_rst_n_o), 64'd0);
        chk("rw_gate", 64'(meas_gate_o), 64'd0);
        chk("rw_valid", 64'(res_valid_o), 64'd0);
        chk("rw_data", res_data_o, 64'd0);
        chk("rw_busy", 64'(busy_o), 64'd0);
        chk("rw_tmo", 64'(timeout_o), 64'd0);
        chk("rw_cnt", 64'(meas_cnt_o), 64'd0);

        // Continuous with 50 cycles of backpressure on the first result.
        start_meas(20, 1'b1);
        round(20, 4, 64'h0000_0014_0000_0011, 50, 1'b1, 1'b1);
        round(20, 2, 64'h0000_0014_0000_0012, 0, 1'b1, 1'b0);
        round(20, 7, 64'h0000_0014_0000_0013, 1, 1'b1, 1'b0);
        chk("cont_cnt3", 64'(meas_cnt_o), 64'd3);
        stop_now();

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            int g;
            int nr;
            bit cont;
            g    = int'($urandom_range(0, 24));
            cont = 1'($urandom_range(0, 1));
            nr   = cont ? int'($urandom_range(1, 3)) : 1;
            start_meas(g, cont);
            for (int k = 0; k < nr; k++) begin
                round(g, int'($urandom_range(0, 15)), {$urandom, $urandom},
                      int'($urandom_range(0, 5)), cont, 1'($urandom_range(0, 1)));
            end
            if (cont) stop_now();
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
